mux_select_sequencer: RTL
=========================

Name: mux_select_sequencer

Overview:
Upstream stage for the 7-to-1 switch multiplexer: generates the 3-bit MuxSelect that steps through inputs 0..6 so the mux output walks the switch bits over time. Contains a rate divider (free-run mode) and a single-step mode driven by a pushbutton. Also supports synchronous load of a start index. Emits per-step and per-wrap pulses for downstream display/capture logic.

Parameters:
TICK_DIV, 50000000, clock cycles per step in free-run mode (>=2); set to 4 in simulation.
NUM_INPUTS, 7, number of mux inputs; select wraps after NUM_INPUTS-1.
SEL_W, 3, MuxSelect width; must satisfy 2**SEL_W >= NUM_INPUTS.

Ports:
Clock  input  1  system clock; all state updates on rising edge.
Resetn  input  1  asynchronous, active-low reset.
Enable  input  1  1 = sequencer active; 0 = freeze all state.
Mode  input  1  0 = free-run via rate divider; 1 = single-step on StepReq.
StepReq  input  1  step request level, synchronous to Clock; rising edge = one step.
Load  input  1  synchronous load of LoadValue into MuxSelect.
LoadValue  input  SEL_W  start index for Load.
MuxSelect  output  SEL_W  registered select to the 7-to-1 mux.
Tick  output  1  one-cycle pulse on the edge where MuxSelect advances.
Wrap  output  1  one-cycle pulse when MuxSelect advances from NUM_INPUTS-1 to 0.

Behaviour:
- Clock is the only clock. Resetn is asynchronous and active-low.
- Reset values: MuxSelect=0, Tick=0, Wrap=0, divider count=TICK_DIV-1, step edge register=0.
- Divider: in Mode 0 with Enable=1, counts down one per cycle. When it reaches 0 it issues an advance and reloads TICK_DIV-1. The first advance after reset is therefore TICK_DIV cycles after Resetn deasserts.
- Single-step: the step edge register captures StepReq every cycle, including while Enable=0. An advance fires when StepReq=1, the registered value is 0, Mode=1 and Enable=1. In Mode 1 the divider is held at TICK_DIV-1.
- Advance: MuxSelect <= MuxSelect+1, or 0 if MuxSelect==NUM_INPUTS-1. Tick=1 in the cycle the new value appears. Wrap=1 in that same cycle only if wrapping. Otherwise Tick=Wrap=0.
- Priority, highest first: Resetn, Load, Enable=0, advance.
- Load (independent of Enable): MuxSelect <= LoadValue if LoadValue<NUM_INPUTS, else 0. Divider reloads TICK_DIV-1. Tick=Wrap=0. A coincident advance is dropped.
- Enable=0: MuxSelect and divider hold. Tick=Wrap=0.
- Mode change: a 0->1 change reloads the divider. A 1->0 change starts a full TICK_DIV period, so no partial-period step occurs.
- MuxSelect never takes values >= NUM_INPUTS. If a corrupted value appears, the next advance forces 0 and asserts Wrap.

Optional Feature:
SEQ_REVERSE_EN
- Defined: adds input port Dir (1 bit). With Dir=1, an advance decrements, and 0 -> NUM_INPUTS-1 asserts Wrap. Dir=0 behaves as the base design. Dir is sampled on the advance edge.
- Undefined: no Dir port; the sequencer counts up only.

Decomposition:
- Package seq_pkg holds SEL_W, NUM_INPUTS, and the mode encoding constants MODE_RUN=0 and MODE_STEP=1.
- Natural sub-module: rate_divider. Inputs: Clock, Resetn, Enable, Clear. Output: one-cycle Pulse.
- The top level holds the select register, edge detect, priority logic and wrap detection.

Test Plan:
- Reset release, TICK_DIV=4, Mode=0, Enable=1 -> MuxSelect 0 for 4 cycles, then 1 with Tick=1. It reaches 6 after 24 cycles, then goes to 0 at cycle 28 with Tick=Wrap=1.
- Mode=1; StepReq held high 10 cycles, then low, then high again -> exactly two advances (0->1->2). Divider pulses none.
- Load=1, LoadValue=5, then run -> 5, 6, then 0 with Wrap=1. LoadValue=7 -> MuxSelect=0.
- Enable=0 mid-count at MuxSelect=3 for 20 cycles -> MuxSelect stays 3 and Tick stays 0. After re-enable the advance occurs after the remaining divider count.
- Resetn pulsed low asynchronously mid-period at MuxSelect=4 -> MuxSelect=0 immediately with no Clock edge; Tick and Wrap are 0.
- SEQ_REVERSE_EN defined, Dir=1, from 0 -> next advance gives 6 with Wrap=1, then 5.

Source files
------------

// File: rtl/mux_select_sequencer_pkg.sv
// Shared types and constants for the mux select sequencer.
// Optional feature macro: SEQ_REVERSE_EN (adds a count-down direction).
package seq_pkg;
  localparam int   NUM_INPUTS = 7;
  localparam int   SEL_W      = 3;
  localparam logic MODE_RUN   = 1'b0;
  localparam logic MODE_STEP  = 1'b1;

  typedef logic [SEL_W-1:0] sel_t;
  typedef struct packed {
    sel_t sel;
    logic wrap;
  } step_t;

  // Out-of-range selects recover to 0 and flag a wrap, whatever the direction.
  function automatic step_t next_sel(sel_t cur, logic down);
    step_t r;
    r.sel  = '0;
    r.wrap = 1'b0;
    if (int'(cur) >= NUM_INPUTS) begin
      r.wrap = 1'b1;
    end else if (down) begin
      if (cur == '0) begin
        r.sel  = sel_t'(NUM_INPUTS - 1);
        r.wrap = 1'b1;
      end else begin
        r.sel = cur - sel_t'(1);
      end
    end else if (int'(cur) == NUM_INPUTS - 1) begin
      r.wrap = 1'b1;
    end else begin
      r.sel = cur + sel_t'(1);
    end
    return r;
  endfunction
endpackage

// File: rtl/mux_select_sequencer_if.sv
// Control/status bundle between the sequencer and its driver.
// Optional feature macro: SEQ_REVERSE_EN adds the Dir signal.
interface mux_select_sequencer_if;
  import seq_pkg::*;
  logic Enable;
  logic Mode;
  logic StepReq;
  logic Load;
  sel_t LoadValue;
  sel_t MuxSelect;
  logic Tick;
  logic Wrap;
`ifdef SEQ_REVERSE_EN
  logic Dir;
  modport master (output Enable, Mode, StepReq, Load, LoadValue, Dir,
                  input  MuxSelect, Tick, Wrap);
  modport slave  (input  Enable, Mode, StepReq, Load, LoadValue, Dir,
                  output MuxSelect, Tick, Wrap);
`else
  modport master (output Enable, Mode, StepReq, Load, LoadValue,
                  input  MuxSelect, Tick, Wrap);
  modport slave  (input  Enable, Mode, StepReq, Load, LoadValue,
                  output MuxSelect, Tick, Wrap);
`endif
endinterface

// File: rtl/mux_select_sequencer_rate_divider.sv
// Down-counting rate divider: one-cycle Pulse every TICK_DIV enabled cycles.
// Clear reloads the full period and suppresses the pulse.
module rate_divider #(
  parameter int TICK_DIV = 50000000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic Enable,
  input  logic Clear,
  output logic Pulse
);
  localparam int            CW  = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign Pulse = Enable && !Clear && (cnt == '0);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)             cnt <= TOP;
    else if (Clear || Pulse) cnt <= TOP;
    else if (Enable)         cnt <= cnt - CW'(1);
  end
endmodule

// File: rtl/mux_select_sequencer.sv
// Generates the 7-to-1 mux select, stepping by rate divider or pushbutton edge.
// Optional feature macro: SEQ_REVERSE_EN (Dir=1 counts down).
module mux_select_sequencer
  import seq_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  mux_select_sequencer_if.slave  bus
);
  logic  step_q;
  logic  div_pulse;
  logic  step_adv;
  logic  adv;
  logic  down;
  step_t nxt;

  // Holding the divider cleared in step mode makes a return to run mode
  // start a full period, never a partial one.
  rate_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Enable (bus.Enable && (bus.Mode == MODE_RUN)),
    .Clear  (bus.Load || (bus.Mode == MODE_STEP)),
    .Pulse  (div_pulse)
  );

  assign step_adv = (bus.Mode == MODE_STEP) && bus.StepReq && !step_q;
  assign adv      = bus.Enable && (div_pulse || step_adv);

`ifdef SEQ_REVERSE_EN
  assign down = bus.Dir;
`else
  assign down = 1'b0;
`endif

  assign nxt = next_sel(bus.MuxSelect, down);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      bus.MuxSelect <= '0;
      bus.Tick      <= 1'b0;
      bus.Wrap      <= 1'b0;
      step_q        <= 1'b0;
    end else begin
      step_q   <= bus.StepReq;
      bus.Tick <= 1'b0;
      bus.Wrap <= 1'b0;
      if (bus.Load) begin
        bus.MuxSelect <= (int'(bus.LoadValue) < NUM_INPUTS) ? bus.LoadValue : '0;
      end else if (adv) begin
        bus.MuxSelect <= nxt.sel;
        bus.Tick      <= 1'b1;
        bus.Wrap      <= nxt.wrap;
      end
    end
  end
endmodule
